color_capture_ctrl: RTL and testbench
=====================================

// Module: color_capture_ctrl
// PURPOSE
//  Sequences the nine-sticker colour accumulator for one cube face: clears it, aligns to a whole CCD frame,
//  gates per-pixel accumulation for NUM_FRAMES frames, checks the per-frame sample count, then reports the face done.
//  Sits between the CCD capture timing (Fval/Lval) and the colour-accumulation datapath.
//  Tracks the face index 0..NUM_FACES-1 so the downstream solver knows which face was captured.
// PARAMETERS
//  NUM_FRAMES      4   frames accumulated per face (>=1)
//  FRAME_W         3   width of frame counter; 2**FRAME_W > NUM_FRAMES
//  HITS_PER_FRAME  45  expected PixelHit count per frame (9 blocks x 5-pixel cross)
//  HIT_W           6   width of hit counter; 2**HIT_W > HITS_PER_FRAME
//  NUM_FACES       6   faces per cube
// PORTS
//  Clk          in   1        system clock (CCD pixel clock domain)
//  Reset        in   1        synchronous, active-high reset
//  Start        in   1        request capture of next face; sampled only in IDLE
//  Abort        in   1        abandon current capture; returns to IDLE
//  Fval         in   1        frame valid from CCD capture
//  Lval         in   1        line valid from CCD capture
//  PixelHit     in   1        datapath: current pixel lies on a sample cross
//  AccClear     out  1        one-cycle clear of all nine colour accumulators
//  AccEnable    out  1        accumulate current pixel this cycle
//  FaceIndex    out  3        face being / last captured, 0..NUM_FACES-1
//  FrameCount   out  FRAME_W  frames completed for current face
//  Busy         out  1        high in any state except IDLE
//  FaceDone     out  1        one-cycle pulse: accumulators hold a complete face
//  CubeDone     out  1        level: all NUM_FACES faces captured
//  SampleError  out  1        sticky: some frame had hit count != HITS_PER_FRAME
// BEHAVIOUR
//  Reset (sync, active-high): state IDLE; all outputs 0; fval_d, hit_cnt, frame_cnt, FaceIndex cleared.
//    Reset mid-operation aborts immediately; no FaceDone.
//  fval_d = Fval registered; rise = Fval & ~fval_d; fall = ~Fval & fval_d.
//  States:
//    IDLE:    Start & ~Abort -> ARM; clears SampleError and CubeDone.
//    ARM:     AccClear=1 for exactly this cycle; frame_cnt=0; hit_cnt=0 -> SYNC.
//    SYNC:    wait for rise -> CAPTURE. A frame already in progress (Fval high on entry) is skipped.
//    CAPTURE: AccEnable = Fval & Lval & PixelHit (combinational, zero latency).
//             hit_cnt += AccEnable, saturating at 2**HIT_W-1. fall -> CHECK.
//    CHECK:   one cycle. If hit_cnt != HITS_PER_FRAME, set SampleError. hit_cnt cleared.
//             frame_cnt+1 is registered into FrameCount. frame_cnt+1 == NUM_FRAMES -> DONE, else SYNC.
//             The next rise is caught because it cannot occur within one cycle of fall.
//    DONE:    FaceDone=1 for this cycle only; -> IDLE.
//             FaceIndex increments on exit. At NUM_FACES-1 it wraps to 0 and CubeDone is set.
//  AccEnable is 0 outside CAPTURE. A pixel in the cycle Fval drops is not accumulated.
//  Abort in any non-IDLE state -> IDLE next cycle.
//    No FaceDone; FaceIndex unchanged; FrameCount holds; accumulators are not cleared.
//  Abort & Start together in IDLE: Abort wins.
//  Start outside IDLE is ignored.
//  Busy is registered from the next state, so it rises in the cycle ARM is entered.
// TESTING
//  1 Reset, Start, 4 frames of 45 hits each -> one AccClear, 180 AccEnable cycles, FaceDone pulse,
//    FaceIndex 0->1, SampleError=0.
//  2 Start while Fval high mid-frame -> no AccEnable until next rising Fval; 4 full frames counted.
//  3 Frame 2 delivers 44 hits -> SampleError=1 sticky through FaceDone; cleared by next Start.
//  4 Six full faces back-to-back -> FaceIndex sequence 1..5,0; CubeDone=1 after sixth FaceDone.
//  5 Abort during frame 3 (FrameCount=2) -> IDLE next cycle, no FaceDone, FaceIndex unchanged.
//    Reset during CAPTURE -> all outputs 0 next cycle.
//  6 PixelHit with Lval=0, or in the Fval falling cycle -> AccEnable=0 and hit_cnt unchanged.
//    Start+Abort together -> stays IDLE.

Source files
------------

// File: rtl/color_capture_ctrl.sv
// Capture sequencer for one cube face: clears the colour accumulators, aligns to whole CCD frames,
// gates per-pixel accumulation for NUM_FRAMES frames, checks per-frame hit counts, reports the face.
`timescale 1ns/1ps
module color_capture_ctrl #(
  parameter int unsigned NUM_FRAMES     = 4,
  parameter int unsigned FRAME_W        = 3,
  parameter int unsigned HITS_PER_FRAME = 45,
  parameter int unsigned HIT_W          = 6,
  parameter int unsigned NUM_FACES      = 6
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic               Abort,
  input  logic               Fval,
  input  logic               Lval,
  input  logic               PixelHit,
  output logic               AccClear,
  output logic               AccEnable,
  output logic [2:0]         FaceIndex,
  output logic [FRAME_W-1:0] FrameCount,
  output logic               Busy,
  output logic               FaceDone,
  output logic               CubeDone,
  output logic               SampleError
);

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StSync,
    StCapture,
    StCheck,
    StDone
  } state_e;

  localparam logic [HIT_W-1:0]   HitMax    = '1;
  localparam logic [HIT_W-1:0]   HitTarget = HIT_W'(HITS_PER_FRAME);
  localparam logic [FRAME_W-1:0] FrameLast = FRAME_W'(NUM_FRAMES);
  localparam logic [2:0]         FaceLast  = 3'(NUM_FACES - 1);

  state_e               state_q, state_d;
  logic                 fval_q;
  logic                 rise, fall;
  logic [HIT_W-1:0]     hit_cnt_q;
  logic [FRAME_W-1:0]   frame_cnt_q;
  logic [FRAME_W-1:0]   frame_inc;
  logic                 last_frame;
  logic                 abort_active;
  logic [2:0]           face_q;
  logic                 cube_done_q;
  logic                 sample_error_q;
  logic                 acc_clear_q;
  logic                 face_done_q;
  logic                 busy_q;

  assign rise         = Fval & ~fval_q;
  assign fall         = ~Fval & fval_q;
  assign frame_inc    = frame_cnt_q + FRAME_W'(1);
  assign last_frame   = (frame_inc == FrameLast);
  assign abort_active = Abort && (state_q != StIdle);

  // Zero latency: the datapath accumulates the very pixel presented this cycle.
  assign AccEnable = (state_q == StCapture) & Fval & Lval & PixelHit;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (Start && !Abort) state_d = StArm;
      StArm:     state_d = StSync;
      StSync:    if (rise) state_d = StCapture;
      StCapture: if (fall) state_d = StCheck;
      StCheck:   state_d = last_frame ? StDone : StSync;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
    if (abort_active) state_d = StIdle;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q        <= StIdle;
      fval_q         <= 1'b0;
      hit_cnt_q      <= '0;
      frame_cnt_q    <= '0;
      face_q         <= '0;
      cube_done_q    <= 1'b0;
      sample_error_q <= 1'b0;
      acc_clear_q    <= 1'b0;
      face_done_q    <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q     <= state_d;
      fval_q      <= Fval;
      busy_q      <= (state_d != StIdle);
      acc_clear_q <= (state_d == StArm);
      face_done_q <= (state_d == StDone);

      // An abort freezes every counter so FrameCount and FaceIndex keep their last values.
      if (!abort_active) begin
        case (state_q)
          StIdle: begin
            if (Start && !Abort) begin
              sample_error_q <= 1'b0;
              cube_done_q    <= 1'b0;
            end
          end
          StArm: begin
            frame_cnt_q <= '0;
            hit_cnt_q   <= '0;
          end
          StCapture: begin
            if (AccEnable && (hit_cnt_q != HitMax)) hit_cnt_q <= hit_cnt_q + HIT_W'(1);
          end
          StCheck: begin
            if (hit_cnt_q != HitTarget) sample_error_q <= 1'b1;
            hit_cnt_q   <= '0;
            frame_cnt_q <= frame_inc;
          end
          StDone: begin
            if (face_q == FaceLast) begin
              face_q      <= '0;
              cube_done_q <= 1'b1;
            end else begin
              face_q <= face_q + 3'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign AccClear    = acc_clear_q;
  assign FaceIndex   = face_q;
  assign FrameCount  = frame_cnt_q;
  assign Busy        = busy_q;
  assign FaceDone    = face_done_q;
  assign CubeDone    = cube_done_q;
  assign SampleError = sample_error_q;

endmodule

// File: tb/tb_color_capture_ctrl.sv
// Randomised bench for color_capture_ctrl: a face-level model queues each capture's expected result,
// a negedge monitor checks it whenever FaceDone pulses.
`timescale 1ns/1ps
module tb_color_capture_ctrl;

  localparam int NUM_FRAMES = 4;
  localparam int FRAME_W    = 3;
  localparam int HITS       = 45;
  localparam int NUM_FACES  = 6;

  logic               Clk = 1'b0;
  logic               Reset, Start, Abort, Fval, Lval, PixelHit;
  logic               AccClear, AccEnable, Busy, FaceDone, CubeDone, SampleError;
  logic [2:0]         FaceIndex;
  logic [FRAME_W-1:0] FrameCount;

  color_capture_ctrl #(
    .NUM_FRAMES    (NUM_FRAMES),
    .FRAME_W       (FRAME_W),
    .HITS_PER_FRAME(HITS),
    .HIT_W         (6),
    .NUM_FACES     (NUM_FACES)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .Abort      (Abort),
    .Fval       (Fval),
    .Lval       (Lval),
    .PixelHit   (PixelHit),
    .AccClear   (AccClear),
    .AccEnable  (AccEnable),
    .FaceIndex  (FaceIndex),
    .FrameCount (FrameCount),
    .Busy       (Busy),
    .FaceDone   (FaceDone),
    .CubeDone   (CubeDone),
    .SampleError(SampleError)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int face;
    bit err;
    bit cube;
    int en;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   mdl_face = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_in(input bit f, input bit l, input bit p);
    Fval = f;
    Lval = l;
    PixelHit = p;
  endtask

  task automatic cyc(input bit f, input bit l, input bit p);
    set_in(f, l, p);
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_acc_clear"}, int'(AccClear), 0);
    check({tag, "_acc_enable"}, int'(AccEnable), 0);
    check({tag, "_face_index"}, int'(FaceIndex), 0);
    check({tag, "_frame_count"}, int'(FrameCount), 0);
    check({tag, "_busy"}, int'(Busy), 0);
    check({tag, "_face_done"}, int'(FaceDone), 0);
    check({tag, "_cube_done"}, int'(CubeDone), 0);
    check({tag, "_sample_error"}, int'(SampleError), 0);
  endtask

  // One CCD frame with exactly `hits` qualifying pixels plus decoy PixelHits that must not count.
  task automatic send_frame(input int hits);
    int rem;
    rem = hits;
    repeat (3) cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)));
    cyc(1'b1, 1'b0, 1'($urandom_range(0, 1)));
    while (rem > 0) begin
      case ($urandom_range(0, 3))
        0: begin
          set_in(1'b1, 1'b0, 1'b1);
          #1;
          check("acc_en_lval_low", int'(AccEnable), 0);
          tick();
        end
        1: cyc(1'b1, 1'b1, 1'b0);
        default: begin
          cyc(1'b1, 1'b1, 1'b1);
          rem--;
        end
      endcase
    end
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    set_in(1'b0, 1'b1, 1'b1);
    #1;
    check("acc_en_fval_fall", int'(AccEnable), 0);
    tick();
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic start_checks();
    check("start_busy", int'(Busy), 1);
    check("start_acc_clear", int'(AccClear), 1);
    check("start_sample_error_clr", int'(SampleError), 0);
    check("start_cube_done_clr", int'(CubeDone), 0);
  endtask

  task automatic capture_face(input bit mid, input int h0, input int h1, input int h2,
                              input int h3);
    exp_t e;
    e.face = mdl_face;
    e.err  = (h0 != HITS) || (h1 != HITS) || (h2 != HITS) || (h3 != HITS);
    e.cube = (mdl_face == NUM_FACES - 1);
    e.en   = h0 + h1 + h2 + h3;
    sb.push_back(e);
    mdl_face = (mdl_face + 1) % NUM_FACES;
    if (mid) begin
      repeat (3) cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      repeat (4) cyc(1'b1, 1'b1, 1'b1);
      set_in(1'b1, 1'b1, 1'b1);
      Start = 1'b1;
      tick();
      Start = 1'b0;
      start_checks();
      repeat (6) cyc(1'b1, 1'b1, 1'b1);
      cyc(1'b1, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0);
    end else begin
      Start = 1'b1;
      tick();
      Start = 1'b0;
      start_checks();
    end
    send_frame(h0);
    send_frame(h1);
    send_frame(h2);
    send_frame(h3);
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
  endtask

  function automatic int rand_hits();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(40, 50)) : HITS;
  endfunction

  // Monitor: counts AccEnable since the last AccClear and scores each FaceDone.
  initial begin
    int   en_cnt;
    bit   post_pending;
    exp_t cur;
    en_cnt = 0;
    post_pending = 0;
    forever begin
      @(negedge Clk);
      if (Reset) begin
        en_cnt = 0;
        post_pending = 0;
      end else begin
        if (post_pending) begin
          check("face_index_after", int'(FaceIndex), (cur.face + 1) % NUM_FACES);
          check("cube_done_after", int'(CubeDone), int'(cur.cube));
          check("busy_after_done", int'(Busy), 0);
          post_pending = 0;
        end
        if (AccClear) en_cnt = 0;
        if (AccEnable) en_cnt++;
        if (FaceDone) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_face_done: got pulse, expected none");
          end else begin
            cur = sb.pop_front();
            check("face_index_done", int'(FaceIndex), cur.face);
            check("sample_error_done", int'(SampleError), int'(cur.err));
            check("frame_count_done", int'(FrameCount), NUM_FRAMES);
            check("acc_enable_total", en_cnt, cur.en);
            post_pending = 1;
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    Reset = 1'b1;
    Start = 1'b0;
    Abort = 1'b0;
    set_in(1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    check_all_zero("reset");
    Reset = 1'b0;
    tick();

    capture_face(1'b0, 45, 45, 45, 45);
    capture_face(1'b1, 45, 45, 45, 45);
    capture_face(1'b0, 45, 44, 45, 45);
    check("sample_error_sticky", int'(SampleError), 1);

    // Abort during the third frame.
    Start = 1'b1;
    tick();
    Start = 1'b0;
    start_checks();
    send_frame(45);
    send_frame(45);
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    repeat (5) cyc(1'b1, 1'b1, 1'b1);
    check("frame_count_mid", int'(FrameCount), 2);
    check("busy_mid", int'(Busy), 1);
    set_in(1'b1, 1'b1, 1'b1);
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    check("abort_busy", int'(Busy), 0);
    check("abort_face_done", int'(FaceDone), 0);
    check("abort_face_index", int'(FaceIndex), mdl_face);
    check("abort_frame_count", int'(FrameCount), 2);
    check("abort_acc_enable", int'(AccEnable), 0);
    repeat (3) cyc(1'b1, 1'b1, 1'b1);
    repeat (4) cyc(1'b0, 1'b0, 1'b0);

    // Reset while capturing.
    Start = 1'b1;
    tick();
    Start = 1'b0;
    send_frame(45);
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    repeat (3) cyc(1'b1, 1'b1, 1'b1);
    set_in(1'b1, 1'b1, 1'b1);
    Reset = 1'b1;
    tick();
    check_all_zero("mid_reset");
    Reset = 1'b0;
    mdl_face = 0;
    repeat (2) cyc(1'b1, 1'b1, 1'b1);
    repeat (4) cyc(1'b0, 1'b0, 1'b0);

    for (int i = 0; i < NUM_FACES; i++) begin
      capture_face(1'b0, rand_hits(), rand_hits(), rand_hits(), rand_hits());
    end
    check("cube_done_final", int'(CubeDone), 1);
    check("face_index_wrap", int'(FaceIndex), 0);

    // Start and Abort together: Abort wins, nothing is cleared.
    Start = 1'b1;
    Abort = 1'b1;
    tick();
    Start = 1'b0;
    Abort = 1'b0;
    check("start_abort_busy", int'(Busy), 0);
    check("start_abort_acc_clear", int'(AccClear), 0);
    check("start_abort_cube_done", int'(CubeDone), 1);
    tick();
    check("start_abort_busy_2", int'(Busy), 0);

    repeat (5) tick();
    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
